// File: rtl/hub75_capture.sv
// rtl/hub75_capture.sv - HUB75 receiver rebuilding BCM bit-planes into a {y,x} pixel write stream
// Optional counters (frame_cnt, err_cnt, oe_lit_cycles) exist only with HUB75_CAPTURE_STATS_EN.
module hub75_capture #(
  parameter int WIDTH       = 64,
  parameter int HEIGHT      = 64,
  parameter int COLOR_DEPTH = 6,
  parameter int ROW_BITS    = 5
) (
  input  logic                     display_clock,
  input  logic                     reset,
  input  logic                     hub_clk,
  input  logic                     hub_stb,
  input  logic                     hub_oe,
  input  logic [ROW_BITS-1:0]      hub_row,
  input  logic [5:0]               hub_rgb,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_addr,
  output logic [3*COLOR_DEPTH-1:0] out_data,
  output logic                     line_err,
  output logic                     overrun
`ifdef HUB75_CAPTURE_STATS_EN
  ,
  output logic [15:0]              frame_cnt,
  output logic [15:0]              err_cnt,
  output logic [23:0]              oe_lit_cycles
`endif
);
  localparam int DW = 3*COLOR_DEPTH;
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(WIDTH+1);
  localparam int PW = $clog2(COLOR_DEPTH+1);
  localparam int WW = $clog2(2*WIDTH);
  localparam int SW = ROW_BITS + 8;
  localparam logic [CW-1:0] COL_FULL   = CW'(WIDTH);
  localparam logic [PW-1:0] PLANE_END  = PW'(COLOR_DEPTH);
  localparam logic [PW-1:0] PLANE_LAST = PW'(COLOR_DEPTH-1);
  localparam logic [WW-1:0] WORD_LAST  = WW'(2*WIDTH-1);
  localparam logic [WW-1:0] WORD_HALF  = WW'(WIDTH);

  typedef enum logic {IDLE, EMIT} state_t;

  logic [SW-1:0]       sync1_q, sync2_q;
  logic                clk_prev_q, stb_prev_q;
  logic                clk_s, stb_s, clk_rise, stb_rise;
  logic [ROW_BITS-1:0] row_s;
  logic [5:0]          rgb_s;

  logic [CW-1:0]       col_q, col_d, col_eff;
  logic [PW-1:0]       plane_q, plane_d, plane_eff;
  logic [ROW_BITS-1:0] last_row_q, last_row_d, emit_row_q, emit_row_d;
  logic                row_bad_q, row_bad_d, bad;
  logic                line_err_q, line_err_d, overrun_q, overrun_d;
  logic                start, emit_idle, hs, emit_last;
  state_t              state_q, state_d;
  logic [WW-1:0]       word_q, word_d;

  logic [5:0]    line_buf_q [WIDTH];
  logic [5:0]    line_buf_d [WIDTH];
  logic [DW-1:0] acc_top_q  [WIDTH];
  logic [DW-1:0] acc_top_d  [WIDTH];
  logic [DW-1:0] acc_bot_q  [WIDTH];
  logic [DW-1:0] acc_bot_d  [WIDTH];
  logic [DW-1:0] emit_top_q [WIDTH];
  logic [DW-1:0] emit_top_d [WIDTH];
  logic [DW-1:0] emit_bot_q [WIDTH];
  logic [DW-1:0] emit_bot_d [WIDTH];

  logic          bottom;
  logic [XW-1:0] x_idx;
  logic [5:0]    y_addr;

  assign {stb_s, clk_s, row_s, rgb_s} = sync2_q;
  assign clk_rise  = clk_s & ~clk_prev_q;
  assign stb_rise  = stb_s & ~stb_prev_q;
  assign hs        = (state_q == EMIT) && out_ready;
  assign emit_last = (word_q == WORD_LAST);
  // The emitter frees up in the same cycle as its final handshake, allowing back-to-back rows.
  assign emit_idle = (state_q == IDLE) || (hs && emit_last);
  assign line_err  = line_err_q;
  assign overrun   = overrun_q;

  always_comb begin
    col_d      = col_q;
    plane_d    = plane_q;
    last_row_d = last_row_q;
    row_bad_d  = row_bad_q;
    emit_row_d = emit_row_q;
    line_buf_d = line_buf_q;
    acc_top_d  = acc_top_q;
    acc_bot_d  = acc_bot_q;
    emit_top_d = emit_top_q;
    emit_bot_d = emit_bot_q;
    col_eff    = col_q;
    plane_eff  = plane_q;
    bad        = row_bad_q;
    start      = 1'b0;
    line_err_d = 1'b0;
    overrun_d  = 1'b0;
    // Shift clock is handled first so a coincident strobe sees the final column.
    if (clk_rise && (col_q < COL_FULL)) begin
      line_buf_d[col_q[XW-1:0]] = rgb_s;
      col_eff = col_q + CW'(1);
    end
    col_d = col_eff;
    if (stb_rise) begin
      plane_eff = ((row_s != last_row_q) || (plane_q == PLANE_END)) ? '0 : plane_q;
      bad = row_bad_q && (plane_eff != '0);
      for (int c = 0; c < WIDTH; c++) begin
        for (int ch = 0; ch < 3; ch++) begin
          acc_top_d[c][ch*COLOR_DEPTH + int'(plane_eff)] = (col_eff == COL_FULL) & line_buf_d[c][ch];
          acc_bot_d[c][ch*COLOR_DEPTH + int'(plane_eff)] = (col_eff == COL_FULL) & line_buf_d[c][ch+3];
        end
      end
      if (col_eff != COL_FULL) begin
        line_err_d = 1'b1;
        bad        = 1'b1;
      end
      last_row_d = row_s;
      plane_d    = plane_eff + PW'(1);
      col_d      = '0;
      row_bad_d  = bad;
      if ((plane_eff == PLANE_LAST) && !bad) begin
        if (emit_idle) begin
          start      = 1'b1;
          emit_top_d = acc_top_d;
          emit_bot_d = acc_bot_d;
          emit_row_d = row_s;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EMIT;
          word_d  = '0;
        end
      end
      EMIT: begin
        if (hs) begin
          if (emit_last) begin
            state_d = start ? EMIT : IDLE;
            word_d  = '0;
          end else begin
            word_d = word_q + WW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == EMIT);
    bottom    = (word_q >= WORD_HALF);
    x_idx     = bottom ? XW'(word_q - WORD_HALF) : XW'(word_q);
    y_addr    = 6'(emit_row_q) + (bottom ? 6'(HEIGHT/2) : 6'd0);
    out_addr  = '0;
    out_data  = '0;
    if (out_valid) begin
      out_addr = {4'd0, y_addr, 6'(x_idx)};
      out_data = bottom ? emit_bot_q[x_idx] : emit_top_q[x_idx];
    end
  end

  always_ff @(posedge display_clock or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      clk_prev_q <= 1'b0;
      stb_prev_q <= 1'b0;
      col_q      <= '0;
      plane_q    <= '0;
      last_row_q <= '1;
      row_bad_q  <= 1'b0;
      emit_row_q <= '0;
      line_err_q <= 1'b0;
      overrun_q  <= 1'b0;
      state_q    <= IDLE;
      word_q     <= '0;
    end else begin
      sync1_q    <= {hub_stb, hub_clk, hub_row, hub_rgb};
      sync2_q    <= sync1_q;
      clk_prev_q <= clk_s;
      stb_prev_q <= stb_s;
      col_q      <= col_d;
      plane_q    <= plane_d;
      last_row_q <= last_row_d;
      row_bad_q  <= row_bad_d;
      emit_row_q <= emit_row_d;
      line_err_q <= line_err_d;
      overrun_q  <= overrun_d;
      state_q    <= state_d;
      word_q     <= word_d;
    end
  end

  always_ff @(posedge display_clock) begin
    line_buf_q <= line_buf_d;
    acc_top_q  <= acc_top_d;
    acc_bot_q  <= acc_bot_d;
    emit_top_q <= emit_top_d;
    emit_bot_q <= emit_bot_d;
  end

`ifdef HUB75_CAPTURE_STATS_EN
  logic [1:0]  oe_sync_q;
  logic [15:0] frame_cnt_q, err_cnt_q;
  logic [23:0] oe_lit_q;

  assign frame_cnt     = frame_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign oe_lit_cycles = oe_lit_q;

  always_ff @(posedge display_clock or posedge reset) begin
    if (reset) begin
      oe_sync_q   <= 2'b11;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      oe_lit_q    <= '0;
    end else begin
      oe_sync_q <= {oe_sync_q[0], hub_oe};
      if (!oe_sync_q[1]) oe_lit_q <= oe_lit_q + 24'd1;
      if (start && (row_s == '0) && (emit_row_q == ROW_BITS'(HEIGHT/2-1)))
        frame_cnt_q <= frame_cnt_q + 16'd1;
      if ((line_err_q || overrun_q) && (err_cnt_q != 16'hFFFF))
        err_cnt_q <= err_cnt_q + 16'd1;
    end
  end
`else
  logic unused_oe;
  assign unused_oe = hub_oe;
`endif

endmodule

// File: tb/tb_hub75_capture.sv
// tb/tb_hub75_capture.sv - scoreboard bench driving HUB75 planes built from a per-row pixel image
module tb_hub75_capture;
  localparam int W  = 64;
  localparam int H  = 64;
  localparam int CD = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hub_clk = 1'b0;
  logic        hub_stb = 1'b0;
  logic        hub_oe = 1'b1;
  logic [4:0]  hub_row = 5'd0;
  logic [5:0]  hub_rgb = 6'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_addr;
  logic [17:0] out_data;
  logic        line_err;
  logic        overrun;

  int total = 0;
  int bad = 0;
  int lerr_cnt = 0;
  int ovr_cnt = 0;
  int hs_cnt = 0;
  int ready_mode = 1;
  int base;

  logic [33:0] sb [$];
  logic [17:0] top_px [W];
  logic [17:0] bot_px [W];

  hub75_capture #(.WIDTH(W), .HEIGHT(H), .COLOR_DEPTH(CD), .ROW_BITS(5)) dut (
    .display_clock(clk), .reset(reset), .hub_clk(hub_clk), .hub_stb(hub_stb),
    .hub_oe(hub_oe), .hub_row(hub_row), .hub_rgb(hub_rgb), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .line_err(line_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Every presented word must match the head of the expected queue, held or not.
  always @(negedge clk) begin
    if (!reset) begin
      if (line_err) lerr_cnt++;
      if (overrun) ovr_cnt++;
      if (out_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %0h data %0h, want no write", out_addr, out_data);
        end else begin
          check("word_addr", 64'(out_addr), 64'(sb[0][33:18]));
          check("word_data", 64'(out_data), 64'(sb[0][17:0]));
          if (out_ready) begin
            void'(sb.pop_front());
            hs_cnt++;
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_px();
    for (int x = 0; x < W; x++) begin
      top_px[x] = '0;
      bot_px[x] = '0;
    end
  endtask

  task automatic rand_px();
    for (int x = 0; x < W; x++) begin
      top_px[x] = 18'($urandom);
      bot_px[x] = 18'($urandom);
    end
  endtask

  task automatic push_row(input int row);
    logic [5:0] y;
    for (int half = 0; half < 2; half++) begin
      y = 6'(row + half*H/2);
      for (int x = 0; x < W; x++)
        sb.push_back({4'd0, y, 6'(x), (half != 0) ? bot_px[x] : top_px[x]});
    end
  endtask

  // Plane p carries bit p of each channel; bad_plane gets one shift clock short.
  task automatic send_row(input int row, input int nplanes, input int bad_plane, input bit expect_out);
    int ncols;
    for (int p = 0; p < nplanes; p++) begin
      hub_row = 5'(row);
      ncols = (p == bad_plane) ? W-1 : W;
      for (int x = 0; x < ncols; x++) begin
        hub_rgb = {bot_px[x][12+p], bot_px[x][6+p], bot_px[x][p],
                   top_px[x][12+p], top_px[x][6+p], top_px[x][p]};
        hub_clk = 1'b0;
        wait_cyc(2);
        hub_clk = 1'b1;
        wait_cyc(2);
      end
      hub_clk = 1'b0;
      wait_cyc(2);
      if (expect_out && (p == CD-1)) push_row(row);
      hub_stb = 1'b1;
      wait_cyc(2);
      hub_stb = 1'b0;
      wait_cyc(2);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 6000 && sb.size() > 0; i++) @(posedge clk);
    wait_cyc(5);
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    wait_cyc(3);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_addr", 64'(out_addr), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_line_err", 64'(line_err), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    reset = 1'b0;
    wait_cyc(3);
    check("idle_valid", 64'(out_valid), 64'd0);

    clear_px();
    top_px[3] = 18'h3FFFF;
    send_row(5, CD, -1, 1'b1);
    drain();
    check("loopback_line_err", 64'(lerr_cnt), 64'd0);

    clear_px();
    top_px[10] = 18'h00021;
    send_row(2, CD, -1, 1'b1);
    drain();

    ready_mode = 2;
    for (int r = 0; r < 3; r++) begin
      rand_px();
      send_row(int'($urandom_range(0, 31)), CD, -1, 1'b1);
    end
    drain();
    ready_mode = 1;

    rand_px();
    send_row(9, CD, 3, 1'b0);
    check("short_line_err", 64'(lerr_cnt), 64'd1);
    rand_px();
    send_row(9, CD, -1, 1'b1);
    drain();

    ready_mode = 0;
    rand_px();
    send_row(12, CD, -1, 1'b1);
    rand_px();
    send_row(13, CD, -1, 1'b0);
    wait_cyc(10);
    check("overrun_pulses", 64'(ovr_cnt), 64'd1);
    check("held_valid", 64'(out_valid), 64'd1);
    check("held_queue", 64'(sb.size()), 64'd128);
    ready_mode = 1;
    drain();

    rand_px();
    send_row(7, 4, -1, 1'b0);
    rand_px();
    send_row(8, CD, -1, 1'b1);
    drain();

    rand_px();
    base = hs_cnt;
    send_row(20, CD, -1, 1'b1);
    for (int i = 0; i < 3000 && hs_cnt < base + 40; i++) @(posedge clk);
    check("hs_before_reset", 64'(hs_cnt - base), 64'd40);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    check("valid_after_reset", 64'(out_valid), 64'd0);
    sb.delete();
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(300);
    rand_px();
    send_row(21, CD, -1, 1'b1);
    drain();

    check("final_line_err", 64'(lerr_cnt), 64'd1);
    check("final_overrun", 64'(ovr_cnt), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
